// File: rtl/mips32_mem_arbiter.sv
// Shares one single-ported memory between the IF fetch port and the MEM data port.
// Latency: x_gnt to x_rvalid is MEM_LAT+1 cycles; one transaction in flight, next grant on the edge after rvalid.
// Backpressure: requests are held until x_gnt; data wins ties unless a fetch has lost STARVE_MAX contested grants.
//
// Ports:
//   clk1, rst_n                     clock, async active-low reset
//   if_req/if_addr/if_flush         fetch request, word address, discard in-flight fetch response
//   if_gnt/if_rvalid/if_rdata       fetch grant pulse, data-valid pulse, instruction
//   d_req/d_we/d_addr/d_wdata       data request (load/store), address, store data
//   d_gnt/d_rvalid/d_rdata          data grant pulse, completion pulse, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   single-port memory interface
module mips32_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LOAD   = CW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          kill;
  logic          d_is_store;

  // Arbitration decision taken in IDLE; the result is registered below.
  logic grant_d;
  logic grant_if;

  always_comb begin
    grant_d  = d_req && (!if_req || (starve_cnt < STARVE_TOP));
    grant_if = if_req && !grant_d;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      kill       <= 1'b0;
      d_is_store <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      d_gnt      <= 1'b0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Pulsed outputs default low every cycle.
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;

      case (state)
        IDLE: begin
          kill <= 1'b0;
          if (grant_d) begin
            state      <= BUSY_D;
            d_gnt      <= 1'b1;
            mem_en     <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            d_is_store <= d_we;
            lat_cnt    <= LAT_LOAD;
            // Only a contested data grant counts against the waiting fetch.
            if (if_req && (starve_cnt != STARVE_TOP))
              starve_cnt <= starve_cnt + 1'b1;
          end else if (grant_if) begin
            state      <= BUSY_IF;
            if_gnt     <= 1'b1;
            mem_en     <= 1'b1;
            mem_addr   <= if_addr;
            lat_cnt    <= LAT_LOAD;
            starve_cnt <= '0;
          end
        end

        BUSY_IF: begin
          // A flush seen in the completion cycle still suppresses the response.
          if (if_flush)
            kill <= 1'b1;
          if (lat_cnt == '0) begin
            state <= IDLE;
            kill  <= 1'b0;
            if (!kill && !if_flush) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        BUSY_D: begin
          if (lat_cnt == '0) begin
            state    <= IDLE;
            d_rvalid <= 1'b1;
            // Stores acknowledge without touching the load data register.
            if (!d_is_store)
              d_rdata <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with a MEM_LAT=2 memory model.
// Inputs are driven and outputs sampled on the falling edge of clk1.
// Each scenario task does its own checks; one summary line at the end.
module tb_mips32_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk1;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk1     (clk1),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Memory model: read data appears two cycles after the mem_en cycle.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  assign mem_rdata = rd2;

  always @(posedge clk1) begin
    if (mem_en && mem_we)
      mem[mem_addr] <= mem_wdata;
    if (mem_en)
      rd1 <= mem[mem_addr];
    else
      rd1 <= 32'hBAD0_BAD0;
    rd2 <= rd1;
  end

  task automatic step();
    @(posedge clk1);
    @(negedge clk1);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we});
    end
    checks++;
    if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got if_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h expected 0",
               if_rdata, d_rdata, mem_addr, mem_wdata);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 10'd5;
    step();
    checks++;
    if ({if_gnt, mem_en, mem_we} !== 3'b110 || mem_addr !== 10'd5) begin
      errors++;
      $display("FAIL fetch_grant: got gnt/en/we=%b addr=%0d expected 110 addr=5", {if_gnt, mem_en, mem_we}, mem_addr);
    end
    if_req = 1'b0;
    step();
    checks++;
    if ({if_gnt, mem_en} !== 2'b00 || mem_addr !== 10'd5) begin
      errors++;
      $display("FAIL fetch_pulse: got gnt/en=%b addr=%0d expected 00 addr=5", {if_gnt, mem_en}, mem_addr);
    end
    step();
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_early_rvalid: got %b expected 0", if_rvalid);
    end
    step();
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h2800000A) begin
      errors++;
      $display("FAIL fetch_data: got rvalid=%b rdata=%h expected 1 2800000a", if_rvalid, if_rdata);
    end
    step();
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rvalid_pulse: got %b expected 0", if_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] gm;
    logic [12:0] rm;
    gm = '0; rm = '0;
    if_req = 1'b1; if_addr = 10'd5;
    for (int i = 1; i <= 12; i++) begin
      step();
      gm[i] = if_gnt;
      rm[i] = if_rvalid;
    end
    if_req = 1'b0;
    checks++;
    if (gm !== 13'h0222) begin
      errors++;
      $display("FAIL b2b_grants: got %b expected %b", gm, 13'h0222);
    end
    checks++;
    if (rm !== 13'h1110) begin
      errors++;
      $display("FAIL b2b_rvalids: got %b expected %b", rm, 13'h1110);
    end
    step();
  endtask

  task automatic test_load_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd9; d_wdata = 32'h0000DEAD;
    step();
    checks++;
    if ({d_gnt, mem_en, mem_we} !== 3'b111 || mem_addr !== 10'd9 || mem_wdata !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL store_grant: got gnt/en/we=%b addr=%0d wdata=%h expected 111 9 0000dead",
               {d_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    d_req = 1'b0;
    step(); step(); step();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL store_ack: got rvalid=%b rdata=%h expected 1 00000000", d_rvalid, d_rdata);
    end
    d_req = 1'b1; d_we = 1'b0;
    step();
    checks++;
    if ({d_gnt, mem_en, mem_we} !== 3'b110) begin
      errors++;
      $display("FAIL load_grant: got gnt/en/we=%b expected 110", {d_gnt, mem_en, mem_we});
    end
    d_req = 1'b0;
    step(); step(); step();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL load_data: got rvalid=%b rdata=%h expected 1 0000dead", d_rvalid, d_rdata);
    end
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'd10; d_wdata = 32'h00001234;
    step();
    d_req = 1'b0;
    step(); step(); step();
    checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'h0000DEAD) begin
      errors++;
      $display("FAIL store_keeps_rdata: got rvalid=%b rdata=%h expected 1 0000dead", d_rvalid, d_rdata);
    end
    step();
  endtask

  task automatic test_contention();
    logic [7:0] seq;
    int n;
    seq = '0; n = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
    if_req = 1'b1; if_addr = 10'd5;
    for (int i = 0; i < 40; i++) begin
      step();
      if (d_gnt && if_gnt) begin
        checks++;
        errors++;
        $display("FAIL dual_grant: got d_gnt=1 if_gnt=1 expected one grant");
      end
      if (n < 8 && d_gnt) begin
        seq[n] = 1'b0;
        n++;
      end else if (n < 8 && if_gnt) begin
        seq[n] = 1'b1;
        n++;
        checks++;
        if (dut.starve_cnt !== 2'd0) begin
          errors++;
          $display("FAIL starve_clear: got %0d expected 0", dut.starve_cnt);
        end
      end
      if (n == 8) break;
    end
    d_req = 1'b0; if_req = 1'b0;
    checks++;
    if (n != 8 || seq !== 8'b1000_1000) begin
      errors++;
      $display("FAIL grant_order: got %0d grants seq=%b expected 8 seq=10001000 (bit0 first, 1=IF)", n, seq);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 10'd6;
    step();
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_grant: got %b expected 1", if_gnt);
    end
    if_req = 1'b0;
    step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    step();
    checks++;
    if (if_rvalid !== 1'b0 || if_rdata !== 32'h2800000A) begin
      errors++;
      $display("FAIL flush_kill: got rvalid=%b rdata=%h expected 0 2800000a", if_rvalid, if_rdata);
    end
    if_req = 1'b1; if_addr = 10'd6;
    step();
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_next_grant: got %b expected 1", if_gnt);
    end
    if_req = 1'b0;
    step(); step(); step();
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h11111111) begin
      errors++;
      $display("FAIL flush_after_kill: got rvalid=%b rdata=%h expected 1 11111111", if_rvalid, if_rdata);
    end
    // Flush held across the rvalid cycle into IDLE must not touch the next fetch.
    if_flush = 1'b1; if_req = 1'b1; if_addr = 10'd5;
    step();
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle_grant: got %b expected 1", if_gnt);
    end
    if_flush = 1'b0; if_req = 1'b0;
    step(); step(); step();
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h2800000A) begin
      errors++;
      $display("FAIL flush_idle_noeffect: got rvalid=%b rdata=%h expected 1 2800000a", if_rvalid, if_rdata);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic seen;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'd9;
    if_req = 1'b1; if_addr = 10'd5;
    step();
    checks++;
    if (d_gnt !== 1'b1 || dut.starve_cnt !== 2'd1) begin
      errors++;
      $display("FAIL rst_pre_grant: got d_gnt=%b starve=%0d expected 1 1", d_gnt, dut.starve_cnt);
    end
    d_req = 1'b0; if_req = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we} !== 6'b0 ||
        {if_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got ctrl=%b if_rdata=%h d_rdata=%h mem_addr=%h expected all 0",
               {if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we}, if_rdata, d_rdata, mem_addr);
    end
    checks++;
    if (dut.starve_cnt !== 2'd0) begin
      errors++;
      $display("FAIL rst_starve: got %0d expected 0", dut.starve_cnt);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen = seen | d_rvalid | if_rvalid | mem_en;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_rvalid: got activity=%b expected 0", seen);
    end
    if_req = 1'b1; if_addr = 10'd5;
    step();
    checks++;
    if (if_gnt !== 1'b1 || mem_addr !== 10'd5) begin
      errors++;
      $display("FAIL rst_after_grant: got gnt=%b addr=%0d expected 1 5", if_gnt, mem_addr);
    end
    if_req = 1'b0;
    step(); step(); step();
    checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h2800000A) begin
      errors++;
      $display("FAIL rst_after_data: got rvalid=%b rdata=%h expected 1 2800000a", if_rvalid, if_rdata);
    end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5] = 32'h2800000A;
    mem[6] = 32'h11111111;
    rd1 = '0; rd2 = '0;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    test_reset();
    test_fetch();
    test_back_to_back();
    test_load_store();
    test_contention();
    test_flush();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
